// File: rtl/dmem_dual_port_scheduler_if.sv
// Request, response and dual memory port bundle shared between the cores and the scheduler.
// Signal suffixes (_i/_o) are taken from the scheduler's point of view.
`ifndef NCORES
`define NCORES 4
`endif
`ifndef DMEM_ADDRW
`define DMEM_ADDRW 16
`endif

interface dmem_dual_port_scheduler_if #(
  parameter int NCORES     = `NCORES,
  parameter int ADDR_WIDTH = `DMEM_ADDRW
);
  logic [NCORES-1:0]            req_valid_i;
  logic [NCORES-1:0]            req_ready_o;
  logic [NCORES-1:0]            req_we_i;
  logic [NCORES*ADDR_WIDTH-1:0] req_addr_i;
  logic [NCORES*32-1:0]         req_wdata_i;
  logic [NCORES*4-1:0]          req_wstrb_i;
  logic [NCORES-1:0]            rsp_valid_o;
  logic [NCORES*32-1:0]         rsp_rdata_o;

  logic                  mem_a_en_o;
  logic                  mem_a_we_o;
  logic [ADDR_WIDTH-1:0] mem_a_addr_o;
  logic [31:0]           mem_a_wdata_o;
  logic [3:0]            mem_a_wstrb_o;
  logic [31:0]           mem_a_rdata_i;
  logic                  mem_b_en_o;
  logic                  mem_b_we_o;
  logic [ADDR_WIDTH-1:0] mem_b_addr_o;
  logic [31:0]           mem_b_wdata_o;
  logic [3:0]            mem_b_wstrb_o;
  logic [31:0]           mem_b_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i,
    input  mem_a_rdata_i, mem_b_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o,
    output mem_a_en_o, mem_a_we_o, mem_a_addr_o, mem_a_wdata_o, mem_a_wstrb_o,
    output mem_b_en_o, mem_b_we_o, mem_b_addr_o, mem_b_wdata_o, mem_b_wstrb_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i,
    output mem_a_rdata_i, mem_b_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o,
    input  mem_a_en_o, mem_a_we_o, mem_a_addr_o, mem_a_wdata_o, mem_a_wstrb_o,
    input  mem_b_en_o, mem_b_we_o, mem_b_addr_o, mem_b_wdata_o, mem_b_wstrb_o
  );
endinterface

// File: rtl/dmem_dual_port_scheduler.sv
// Round-robin front end sharing a dual-port data memory between NCORES cores,
// issuing up to two non-conflicting requests per cycle and routing responses back.
`ifndef NCORES
`define NCORES 4
`endif
`ifndef DMEM_ADDRW
`define DMEM_ADDRW 16
`endif

module dmem_dual_port_scheduler #(
  parameter int NCORES     = `NCORES,
  parameter int ADDR_WIDTH = `DMEM_ADDRW,
  parameter int CW         = $clog2(NCORES)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  dmem_dual_port_scheduler_if.slave bus,
  output logic [CW-1:0]          rr_ptr_o,
  output logic [31:0]            conflict_cnt_o
);

  logic [CW-1:0]         r_rr_ptr;
  logic [31:0]           r_conflict_cnt;
  logic                  r_a_issued;
  logic                  r_b_issued;
  logic [CW-1:0]         r_a_idx;
  logic [CW-1:0]         r_b_idx;

  logic                  w_a_found;
  logic                  w_b_found;
  logic [CW-1:0]         w_a_idx;
  logic [CW-1:0]         w_b_idx;
  logic [ADDR_WIDTH-1:0] w_a_addr;
  logic [ADDR_WIDTH-1:0] w_b_addr;
  logic                  w_b_issue;
  logic                  w_conflict;
  logic [CW-1:0]         w_ptr_next;

  // Scan from the pointer with an explicit wrap so non-power-of-two core counts work.
  always_comb begin : p_scan
    int            v_idx;
    logic [CW-1:0] v_sel;
    w_a_found = 1'b0;
    w_b_found = 1'b0;
    w_a_idx   = '0;
    w_b_idx   = '0;
    v_idx     = 0;
    v_sel     = '0;
    for (int k = 0; k < NCORES; k++) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= NCORES) v_idx = v_idx - NCORES;
      v_sel = CW'(v_idx);
      if (bus.req_valid_i[v_sel]) begin
        if (!w_a_found) begin
          w_a_found = 1'b1;
          w_a_idx   = v_sel;
        end else if (!w_b_found) begin
          w_b_found = 1'b1;
          w_b_idx   = v_sel;
        end
      end
    end
  end

  always_comb begin : p_issue
    int v_last;
    w_a_addr   = bus.req_addr_i[int'(w_a_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    w_b_addr   = bus.req_addr_i[int'(w_b_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    w_b_issue  = w_a_found && w_b_found &&
                 (w_a_addr[ADDR_WIDTH-1:2] != w_b_addr[ADDR_WIDTH-1:2]);
    w_conflict = w_a_found && w_b_found && !w_b_issue;
    v_last     = w_b_issue ? int'(w_b_idx) : int'(w_a_idx);
    w_ptr_next = (v_last + 1 == NCORES) ? '0 : CW'(v_last + 1);
  end

  // Idle ports are driven fully to zero so a disabled port can never write.
  always_comb begin
    bus.req_ready_o   = '0;
    bus.mem_a_en_o    = 1'b0;
    bus.mem_a_we_o    = 1'b0;
    bus.mem_a_addr_o  = '0;
    bus.mem_a_wdata_o = '0;
    bus.mem_a_wstrb_o = '0;
    bus.mem_b_en_o    = 1'b0;
    bus.mem_b_we_o    = 1'b0;
    bus.mem_b_addr_o  = '0;
    bus.mem_b_wdata_o = '0;
    bus.mem_b_wstrb_o = '0;
    if (w_a_found) begin
      bus.req_ready_o[w_a_idx] = 1'b1;
      bus.mem_a_en_o    = 1'b1;
      bus.mem_a_we_o    = bus.req_we_i[w_a_idx];
      bus.mem_a_addr_o  = w_a_addr;
      bus.mem_a_wdata_o = bus.req_wdata_i[int'(w_a_idx)*32 +: 32];
      bus.mem_a_wstrb_o = bus.req_wstrb_i[int'(w_a_idx)*4 +: 4];
    end
    if (w_b_issue) begin
      bus.req_ready_o[w_b_idx] = 1'b1;
      bus.mem_b_en_o    = 1'b1;
      bus.mem_b_we_o    = bus.req_we_i[w_b_idx];
      bus.mem_b_addr_o  = w_b_addr;
      bus.mem_b_wdata_o = bus.req_wdata_i[int'(w_b_idx)*32 +: 32];
      bus.mem_b_wstrb_o = bus.req_wstrb_i[int'(w_b_idx)*4 +: 4];
    end
  end

  // Responses are decoded from registered flags, so reset clears them at once.
  always_comb begin
    bus.rsp_valid_o = '0;
    bus.rsp_rdata_o = '0;
    if (r_a_issued) begin
      bus.rsp_valid_o[r_a_idx] = 1'b1;
      bus.rsp_rdata_o[int'(r_a_idx)*32 +: 32] = bus.mem_a_rdata_i;
    end
    if (r_b_issued) begin
      bus.rsp_valid_o[r_b_idx] = 1'b1;
      bus.rsp_rdata_o[int'(r_b_idx)*32 +: 32] = bus.mem_b_rdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr       <= '0;
      r_conflict_cnt <= '0;
      r_a_issued     <= 1'b0;
      r_b_issued     <= 1'b0;
      r_a_idx        <= '0;
      r_b_idx        <= '0;
    end else begin
      r_a_issued <= w_a_found;
      r_b_issued <= w_b_issue;
      r_a_idx    <= w_a_idx;
      r_b_idx    <= w_b_idx;
      if (w_a_found) r_rr_ptr <= w_ptr_next;
      if (w_conflict && (r_conflict_cnt != 32'hFFFF_FFFF))
        r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign rr_ptr_o       = r_rr_ptr;
  assign conflict_cnt_o = r_conflict_cnt;

endmodule

// File: tb/tb_dmem_dual_port_scheduler.sv
// Directed bench for dmem_dual_port_scheduler with four cores and a one-cycle model memory.
module tb_dmem_dual_port_scheduler;
  localparam int NC = 4;
  localparam int AW = 16;

  logic        clk;
  logic        rst;
  logic [1:0]  rr_ptr;
  logic [31:0] conflict_cnt;
  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem [0:255];
  int          checks;
  int          errors;

  dmem_dual_port_scheduler_if #(.NCORES(NC), .ADDR_WIDTH(AW)) bus ();

  dmem_dual_port_scheduler #(.NCORES(NC), .ADDR_WIDTH(AW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus),
    .rr_ptr_o       (rr_ptr),
    .conflict_cnt_o (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model memory: synchronous read, byte-strobed write, preload port for setup.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (bus.mem_a_en_o) begin
      bus.mem_a_rdata_i <= mem[bus.mem_a_addr_o[9:2]];
      if (bus.mem_a_we_o)
        for (int b = 0; b < 4; b++)
          if (bus.mem_a_wstrb_o[b]) mem[bus.mem_a_addr_o[9:2]][8*b +: 8] <= bus.mem_a_wdata_o[8*b +: 8];
    end
    if (bus.mem_b_en_o) begin
      bus.mem_b_rdata_i <= mem[bus.mem_b_addr_o[9:2]];
      if (bus.mem_b_we_o)
        for (int b = 0; b < 4; b++)
          if (bus.mem_b_wstrb_o[b]) mem[bus.mem_b_addr_o[9:2]][8*b +: 8] <= bus.mem_b_wdata_o[8*b +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    bus.req_valid_i = '0;
    bus.req_we_i    = '0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.req_wstrb_i = '0;
  endtask

  task automatic set_req(input int core, input logic we, input logic [AW-1:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    bus.req_valid_i[core]           = 1'b1;
    bus.req_we_i[core]              = we;
    bus.req_addr_i[core*AW +: AW]   = addr;
    bus.req_wdata_i[core*32 +: 32]  = wdata;
    bus.req_wstrb_i[core*4 +: 4]    = wstrb;
  endtask

  task automatic preload(input logic [7:0] widx, input logic [31:0] data);
    pre_en   = 1'b1;
    pre_addr = widx;
    pre_data = data;
    tick();
    pre_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_req();
    tick();
    preload(8'h04, 32'hAAAA_0000);
    preload(8'h08, 32'hBBBB_0000);
    preload(8'h10, 32'h1111_2222);
    tick();
    rst = 1'b0;
    #1;
    checks++; if (rr_ptr !== 2'd0) begin errors++; $display("[TB] FAIL reset_ptr actual=%0d required=0", rr_ptr); end
    checks++; if (bus.rsp_valid_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rsp_valid actual=%b required=0000", bus.rsp_valid_o); end
    checks++; if (bus.rsp_rdata_o !== '0) begin errors++; $display("[TB] FAIL reset_rsp_rdata actual=%h required=0", bus.rsp_rdata_o); end
    checks++; if (conflict_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_conflict actual=%0d required=0", conflict_cnt); end
    checks++; if ({bus.mem_a_en_o, bus.mem_b_en_o} !== 2'b00) begin errors++; $display("[TB] FAIL reset_mem_en actual=%b required=00", {bus.mem_a_en_o, bus.mem_b_en_o}); end
  endtask

  task automatic test_two_reads();
    set_req(0, 1'b0, 16'h0010, 32'h0, 4'h0);
    set_req(2, 1'b0, 16'h0020, 32'h0, 4'h0);
    #1;
    checks++; if (bus.req_ready_o !== 4'b0101) begin errors++; $display("[TB] FAIL reads_ready actual=%b required=0101", bus.req_ready_o); end
    checks++; if (bus.mem_a_addr_o !== 16'h0010) begin errors++; $display("[TB] FAIL reads_a_addr actual=%h required=0010", bus.mem_a_addr_o); end
    checks++; if (bus.mem_b_addr_o !== 16'h0020) begin errors++; $display("[TB] FAIL reads_b_addr actual=%h required=0020", bus.mem_b_addr_o); end
    checks++; if ({bus.mem_a_en_o, bus.mem_b_en_o, bus.mem_a_we_o, bus.mem_b_we_o} !== 4'b1100) begin errors++; $display("[TB] FAIL reads_en_we actual=%b required=1100", {bus.mem_a_en_o, bus.mem_b_en_o, bus.mem_a_we_o, bus.mem_b_we_o}); end
    tick();
    clear_req();
    checks++; if (bus.rsp_valid_o !== 4'b0101) begin errors++; $display("[TB] FAIL reads_rsp_valid actual=%b required=0101", bus.rsp_valid_o); end
    checks++; if (bus.rsp_rdata_o[31:0] !== 32'hAAAA_0000) begin errors++; $display("[TB] FAIL reads_core0_data actual=%h required=aaaa0000", bus.rsp_rdata_o[31:0]); end
    checks++; if (bus.rsp_rdata_o[95:64] !== 32'hBBBB_0000) begin errors++; $display("[TB] FAIL reads_core2_data actual=%h required=bbbb0000", bus.rsp_rdata_o[95:64]); end
    checks++; if (rr_ptr !== 2'd3) begin errors++; $display("[TB] FAIL reads_ptr actual=%0d required=3", rr_ptr); end
  endtask

  task automatic test_wrap();
    set_req(0, 1'b0, 16'h0034, 32'h0, 4'h0);
    set_req(3, 1'b0, 16'h0030, 32'h0, 4'h0);
    #1;
    checks++; if (bus.req_ready_o !== 4'b1001) begin errors++; $display("[TB] FAIL wrap_ready actual=%b required=1001", bus.req_ready_o); end
    checks++; if (bus.mem_a_addr_o !== 16'h0030) begin errors++; $display("[TB] FAIL wrap_a_addr actual=%h required=0030", bus.mem_a_addr_o); end
    checks++; if (bus.mem_b_addr_o !== 16'h0034) begin errors++; $display("[TB] FAIL wrap_b_addr actual=%h required=0034", bus.mem_b_addr_o); end
    tick();
    clear_req();
    checks++; if (rr_ptr !== 2'd1) begin errors++; $display("[TB] FAIL wrap_ptr actual=%0d required=1", rr_ptr); end
    checks++; if (bus.rsp_valid_o !== 4'b1001) begin errors++; $display("[TB] FAIL wrap_rsp_valid actual=%b required=1001", bus.rsp_valid_o); end
  endtask

  task automatic test_single_write();
    set_req(3, 1'b1, 16'h0050, 32'h1234_5678, 4'b1111);
    #1;
    checks++; if (bus.req_ready_o !== 4'b1000) begin errors++; $display("[TB] FAIL single_ready actual=%b required=1000", bus.req_ready_o); end
    checks++; if ({bus.mem_a_we_o, bus.mem_a_wstrb_o} !== 5'b11111) begin errors++; $display("[TB] FAIL single_we_wstrb actual=%b required=11111", {bus.mem_a_we_o, bus.mem_a_wstrb_o}); end
    checks++; if (bus.mem_a_wdata_o !== 32'h1234_5678) begin errors++; $display("[TB] FAIL single_wdata actual=%h required=12345678", bus.mem_a_wdata_o); end
    checks++; if ({bus.mem_b_en_o, bus.mem_b_we_o, bus.mem_b_wstrb_o} !== 6'b0) begin errors++; $display("[TB] FAIL single_b_idle actual=%b required=000000", {bus.mem_b_en_o, bus.mem_b_we_o, bus.mem_b_wstrb_o}); end
    tick();
    clear_req();
    checks++; if (rr_ptr !== 2'd0) begin errors++; $display("[TB] FAIL single_ptr actual=%0d required=0", rr_ptr); end
    checks++; if (bus.rsp_valid_o !== 4'b1000) begin errors++; $display("[TB] FAIL single_rsp_valid actual=%b required=1000", bus.rsp_valid_o); end
  endtask

  task automatic test_conflict();
    set_req(1, 1'b0, 16'h0040, 32'h0, 4'h0);
    set_req(3, 1'b1, 16'h0042, 32'hCAFE_BABE, 4'b1100);
    #1;
    checks++; if (bus.req_ready_o !== 4'b0010) begin errors++; $display("[TB] FAIL conflict_ready actual=%b required=0010", bus.req_ready_o); end
    checks++; if (bus.mem_a_addr_o !== 16'h0040) begin errors++; $display("[TB] FAIL conflict_a_addr actual=%h required=0040", bus.mem_a_addr_o); end
    checks++; if ({bus.mem_b_en_o, bus.mem_b_we_o, bus.mem_b_wstrb_o} !== 6'b0) begin errors++; $display("[TB] FAIL conflict_b_idle actual=%b required=000000", {bus.mem_b_en_o, bus.mem_b_we_o, bus.mem_b_wstrb_o}); end
    tick();
    bus.req_valid_i[1] = 1'b0;
    checks++; if (conflict_cnt !== 32'd1) begin errors++; $display("[TB] FAIL conflict_cnt actual=%0d required=1", conflict_cnt); end
    checks++; if (rr_ptr !== 2'd2) begin errors++; $display("[TB] FAIL conflict_ptr actual=%0d required=2", rr_ptr); end
    checks++; if (bus.rsp_valid_o !== 4'b0010) begin errors++; $display("[TB] FAIL conflict_rsp_valid actual=%b required=0010", bus.rsp_valid_o); end
    checks++; if (bus.rsp_rdata_o[63:32] !== 32'h1111_2222) begin errors++; $display("[TB] FAIL conflict_core1_data actual=%h required=11112222", bus.rsp_rdata_o[63:32]); end
    #1;
    checks++; if (bus.req_ready_o !== 4'b1000) begin errors++; $display("[TB] FAIL retry_ready actual=%b required=1000", bus.req_ready_o); end
    checks++; if ({bus.mem_a_en_o, bus.mem_a_we_o, bus.mem_a_wstrb_o} !== 6'b111100) begin errors++; $display("[TB] FAIL retry_a_ctrl actual=%b required=111100", {bus.mem_a_en_o, bus.mem_a_we_o, bus.mem_a_wstrb_o}); end
    checks++; if (bus.mem_a_addr_o !== 16'h0042) begin errors++; $display("[TB] FAIL retry_a_addr actual=%h required=0042", bus.mem_a_addr_o); end
    checks++; if (bus.mem_a_wdata_o !== 32'hCAFE_BABE) begin errors++; $display("[TB] FAIL retry_a_wdata actual=%h required=cafebabe", bus.mem_a_wdata_o); end
    tick();
    clear_req();
    checks++; if (rr_ptr !== 2'd0) begin errors++; $display("[TB] FAIL retry_ptr actual=%0d required=0", rr_ptr); end
    checks++; if (conflict_cnt !== 32'd1) begin errors++; $display("[TB] FAIL retry_cnt actual=%0d required=1", conflict_cnt); end
    checks++; if (bus.rsp_valid_o !== 4'b1000) begin errors++; $display("[TB] FAIL retry_rsp_valid actual=%b required=1000", bus.rsp_valid_o); end
  endtask

  task automatic test_fairness();
    int rsp_cnt [NC];
    logic [3:0] exp_ready;
    for (int i = 0; i < NC; i++) begin
      rsp_cnt[i] = 0;
      set_req(i, 1'b0, 16'h0100 + 16'(4*i), 32'h0, 4'h0);
    end
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_ready = (k % 2 == 0) ? 4'b0011 : 4'b1100;
      checks++; if (bus.req_ready_o !== exp_ready) begin errors++; $display("[TB] FAIL fair_ready_%0d actual=%b required=%b", k, bus.req_ready_o, exp_ready); end
      tick();
      for (int i = 0; i < NC; i++) if (bus.rsp_valid_o[i]) rsp_cnt[i]++;
    end
    clear_req();
    for (int i = 0; i < NC; i++) begin
      checks++; if (rsp_cnt[i] !== 2) begin errors++; $display("[TB] FAIL fair_rsp_core%0d actual=%0d required=2", i, rsp_cnt[i]); end
    end
    checks++; if (rr_ptr !== 2'd0) begin errors++; $display("[TB] FAIL fair_ptr actual=%0d required=0", rr_ptr); end
    checks++; if (conflict_cnt !== 32'd1) begin errors++; $display("[TB] FAIL fair_cnt actual=%0d required=1", conflict_cnt); end
  endtask

  task automatic test_back_to_back();
    set_req(0, 1'b0, 16'h0040, 32'h0, 4'h0);
    #1;
    checks++; if (bus.req_ready_o !== 4'b0001) begin errors++; $display("[TB] FAIL b2b_ready0 actual=%b required=0001", bus.req_ready_o); end
    tick();
    set_req(0, 1'b0, 16'h0010, 32'h0, 4'h0);
    checks++; if (bus.rsp_valid_o !== 4'b0001) begin errors++; $display("[TB] FAIL b2b_rsp0_valid actual=%b required=0001", bus.rsp_valid_o); end
    checks++; if (bus.rsp_rdata_o[31:0] !== 32'hCAFE_2222) begin errors++; $display("[TB] FAIL b2b_rsp0_data actual=%h required=cafe2222", bus.rsp_rdata_o[31:0]); end
    #1;
    checks++; if (bus.req_ready_o !== 4'b0001) begin errors++; $display("[TB] FAIL b2b_ready1 actual=%b required=0001", bus.req_ready_o); end
    tick();
    clear_req();
    checks++; if (bus.rsp_valid_o !== 4'b0001) begin errors++; $display("[TB] FAIL b2b_rsp1_valid actual=%b required=0001", bus.rsp_valid_o); end
    checks++; if (bus.rsp_rdata_o[31:0] !== 32'hAAAA_0000) begin errors++; $display("[TB] FAIL b2b_rsp1_data actual=%h required=aaaa0000", bus.rsp_rdata_o[31:0]); end
    checks++; if (rr_ptr !== 2'd1) begin errors++; $display("[TB] FAIL b2b_ptr actual=%0d required=1", rr_ptr); end
  endtask

  task automatic test_reset_midflight();
    set_req(0, 1'b0, 16'h0020, 32'h0, 4'h0);
    #1;
    checks++; if (bus.req_ready_o !== 4'b0001) begin errors++; $display("[TB] FAIL midrst_ready actual=%b required=0001", bus.req_ready_o); end
    tick();
    clear_req();
    checks++; if (bus.rsp_valid_o !== 4'b0001) begin errors++; $display("[TB] FAIL midrst_pre_valid actual=%b required=0001", bus.rsp_valid_o); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.rsp_valid_o !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_valid actual=%b required=0000", bus.rsp_valid_o); end
    checks++; if (bus.rsp_rdata_o !== '0) begin errors++; $display("[TB] FAIL midrst_rdata actual=%h required=0", bus.rsp_rdata_o); end
    checks++; if (rr_ptr !== 2'd0) begin errors++; $display("[TB] FAIL midrst_ptr actual=%0d required=0", rr_ptr); end
    checks++; if (conflict_cnt !== 32'd0) begin errors++; $display("[TB] FAIL midrst_cnt actual=%0d required=0", conflict_cnt); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.rsp_valid_o !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_after_%0d actual=%b required=0000", k, bus.rsp_valid_o); end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    pre_en   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    bus.mem_a_rdata_i = '0;
    bus.mem_b_rdata_i = '0;
    test_reset();
    test_two_reads();
    test_wrap();
    test_single_write();
    test_conflict();
    test_fairness();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_dual_port_scheduler.md
# dmem_dual_port_scheduler

Sequential front end that shares the dual-port data memory between `NCORES` cores. Each cycle it selects up to two pending core requests in round-robin order, issues them on memory ports A and B, and routes the read data and completion back to the owning cores one cycle later. It owns the round-robin pointer, the response-routing pipeline and a conflict counter.

## Interface
Parameters:
- `NCORES`, default `` `NCORES `` — number of requesting cores; legal values are 2 or greater.
- `ADDR_WIDTH`, default `` `DMEM_ADDRW `` — byte address width.
- `CW`, default `$clog2(NCORES)` — core index width; derived, do not override.

Ports:
- `clk_i` in 1 — clock.
- `rst_i` in 1 — asynchronous, active-high reset.
- `req_valid_i` in NCORES — per-core request valid.
- `req_ready_o` out NCORES — per-core grant; the handshake completes when valid and ready are both high.
- `req_we_i` in NCORES — per-core write enable.
- `req_addr_i` in NCORES*ADDR_WIDTH — packed byte addresses; core i occupies `[ADDR_WIDTH*(i+1)-1 : ADDR_WIDTH*i]`.
- `req_wdata_i` in NCORES*32 — packed write data.
- `req_wstrb_i` in NCORES*4 — packed byte strobes.
- `rsp_valid_o` out NCORES — per-core completion pulse, for both reads and writes.
- `rsp_rdata_o` out NCORES*32 — packed read data; valid only while the matching `rsp_valid_o` bit is high.
- `mem_a_en_o`, `mem_b_en_o` out 1 — memory port enables.
- `mem_a_we_o`, `mem_b_we_o` out 1 — memory port write enables.
- `mem_a_addr_o`, `mem_b_addr_o` out ADDR_WIDTH — memory port addresses.
- `mem_a_wdata_o`, `mem_b_wdata_o` out 32 — memory port write data.
- `mem_a_wstrb_o`, `mem_b_wstrb_o` out 4 — memory port byte strobes.
- `mem_a_rdata_i`, `mem_b_rdata_i` in 32 — memory read data, synchronous, one-cycle latency.
- `rr_ptr_o` out CW — current round-robin pointer.
- `conflict_cnt_o` out 32 — saturating count of suppressed B issues.

## Operation
- **Candidate A:** the first requesting core found scanning indices `rr_ptr, rr_ptr+1, …` with wrap modulo NCORES.
- **Candidate B:** the next requesting core after A in the same scan.
- **B suppression:** B is issued only if its word address differs from A's, i.e. `addr[ADDR_WIDTH-1:2]` differs. This covers read/read, read/write and write/write pairs. A suppressed B keeps its request asserted and receives no ready.
- **Grants:**
  - `req_ready_o` is one-hot A, or A plus B, or zero.
  - The issued core's `we`, `addr`, `wdata` and `wstrb` drive the matching memory port, with `en=1`.
  - An idle port has `en=0`, `we=0` and `wstrb=0`.
- **Pointer update, on each clock with at least one grant:** `rr_ptr <= (last granted index + 1) mod NCORES`, where the last granted index is B's if B issued, otherwise A's. With no grant the pointer holds. Wrap uses an explicit compare, because NCORES need not be a power of two.
- **Response pipeline:**
  - Registers per port: issued flag and core index.
  - Next cycle, `rsp_valid_o[idx]` pulses and `rsp_rdata_o[idx]` takes that port's rdata.
  - Write responses carry don't-care data.
  - A and B never target the same core, so there is no output collision.
- **Conflict counter:** increments by 1 in every cycle where a B candidate existed but was suppressed. It saturates at `0xFFFFFFFF`.
- **Reset values:**
  - `rr_ptr_o = 0`.
  - `rsp_valid_o = 0`.
  - `rsp_rdata_o = 0`.
  - `conflict_cnt_o = 0`.
  - Pipeline flags cleared.
  - Combinational outputs follow from inputs with pointer 0.

## Timing
- **Request path:** `req_ready_o` and all `mem_*_o` are combinational from `req_valid_i`, `req_addr_i` and `rr_ptr`, in the same cycle N.
- **Response latency:** exactly 1 cycle; `rsp_valid_o` is high in cycle N+1 only, for one cycle.
- **Back-to-back:** a core may present its next request in N+1 and can be granted in N+1 while its N response is being delivered.
- **Throughput:** at most 2 accesses per cycle; at most 1 per core per cycle.
- **Reset mid-operation:** outputs clear immediately (asynchronous). In-flight responses are dropped, and no `rsp_valid_o` appears after reset deasserts unless a new grant occurs.
- **Simultaneous events:** a core may be granted in the same cycle its previous response is delivered; both happen.

## Test plan
Bench uses NCORES=4 and a one-cycle-latency model memory.
- **Reset:** hold `rst_i` high, then release -> `rr_ptr_o=0`, `rsp_valid_o=0000`, `conflict_cnt_o=0`, both `mem_*_en_o=0` with `req_valid_i=0`.
- **Two distinct reads:** ptr=0; cores 0 and 2 read `0x10` and `0x20`; memory holds `0xAAAA0000` and `0xBBBB0000` -> cycle N: `req_ready_o=0101`, A addr `0x10`, B addr `0x20`; N+1: `rsp_valid_o=0101`, core0 data `0xAAAA0000`, core2 data `0xBBBB0000`, `rr_ptr_o=3`.
- **Same-word conflict:** ptr=0; core1 reads `0x40`, core3 writes `0x42` -> only core1 granted, `conflict_cnt_o=1`, `rr_ptr_o=2`; next cycle core3 is granted on port A with `wstrb` intact, `rr_ptr_o=0`.
- **Wrap-around:** ptr=3; cores 0 and 3 request distinct words -> A=core3, B=core0, `rr_ptr_o=1`.
- **Fairness:** all 4 cores request distinct words continuously for 4 cycles -> grants (0,1), (2,3), (0,1), (2,3); each core receives exactly 2 responses.
- **Reset mid-flight:** grant core0 in cycle N; assert `rst_i` during N+1 before the clock edge -> `rsp_valid_o` drops to 0 immediately and no response appears after reset deasserts.
